// File: rtl/fa_bist_pkg.sv
// Shared types and constants for the full-adder BIST controller and its golden model.
package fa_bist_pkg;

   typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

   localparam int unsigned NUM_VEC  = 8;
   localparam int unsigned VEC_W    = 3;
   localparam logic [VEC_W-1:0] LAST_VEC = 3'd7;

   localparam int unsigned A_BIT = 2;
   localparam int unsigned B_BIT = 1;
   localparam int unsigned C_BIT = 0;

endpackage

// File: rtl/fa_bist_ctrl_if.sv
// Stimulus/response and result bundle between the BIST controller and its integrating top.
interface fa_bist_ctrl_if #(parameter int unsigned ERR_W = 4) ();
   import fa_bist_pkg::*;

   logic               start;
   logic               A;
   logic               B;
   logic               C;
   logic               sum_in;
   logic               carry_in;
   logic               busy;
   logic               done;
   logic               pass;
   logic [ERR_W-1:0]   err_count;
   logic [NUM_VEC-1:0] fail_mask;
   logic [VEC_W-1:0]   first_fail;
   logic               fail_valid;

   modport master (
      input  start, sum_in, carry_in,
      output A, B, C, busy, done, pass, err_count, fail_mask, first_fail, fail_valid
   );

   modport slave (
      output start, sum_in, carry_in,
      input  A, B, C, busy, done, pass, err_count, fail_mask, first_fail, fail_valid
   );

endinterface

// File: rtl/fa_golden.sv
// Golden full-adder reference: expected sum and carry for one operand triple.
module fa_golden (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic exp_sum,
   output logic exp_carry
);

   assign exp_sum   = a ^ b ^ c;
   assign exp_carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/fa_bist_ctrl.sv
// Full-adder BIST controller: sweeps all 8 operand vectors, waits SETTLE cycles,
// then compares the FA response against the golden model and accumulates results.
module fa_bist_ctrl
   import fa_bist_pkg::*;
#(
   parameter int unsigned SETTLE = 2,
   parameter int unsigned ERR_W  = 4
) (
   input logic            clk,
   input logic            rst,
   fa_bist_ctrl_if.master bif
);

   localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   state_t             state;
   logic [VEC_W-1:0]   vec;
   logic [SET_W-1:0]   settle;
   logic [VEC_W-1:0]   abc;
   logic               busy_q;
   logic               done_q;
   logic               pass_q;
   logic [ERR_W-1:0]   err_q;
   logic [NUM_VEC-1:0] mask_q;
   logic [VEC_W-1:0]   first_q;
   logic               fvalid_q;

   logic               exp_sum;
   logic               exp_carry;
   logic               mismatch_c;
   logic [ERR_W-1:0]   err_nxt_c;

   fa_golden u_golden (
      .a         (vec[A_BIT]),
      .b         (vec[B_BIT]),
      .c         (vec[C_BIT]),
      .exp_sum   (exp_sum),
      .exp_carry (exp_carry)
   );

   // Response check is only meaningful in the sample cycle; counter saturates.
   always_comb begin
      mismatch_c = 1'b0;
      err_nxt_c  = err_q;
      if (state == SAMPLE) begin
         mismatch_c = (bif.sum_in != exp_sum) || (bif.carry_in != exp_carry);
      end
      if (mismatch_c && (err_q != {ERR_W{1'b1}})) begin
         err_nxt_c = err_q + ERR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         vec      <= '0;
         settle   <= '0;
         abc      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         err_q    <= '0;
         mask_q   <= '0;
         first_q  <= '0;
         fvalid_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (bif.start) begin
                  state    <= APPLY;
                  vec      <= '0;
                  settle   <= '0;
                  abc      <= '0;
                  busy_q   <= 1'b1;
                  done_q   <= 1'b0;
                  pass_q   <= 1'b0;
                  err_q    <= '0;
                  mask_q   <= '0;
                  first_q  <= '0;
                  fvalid_q <= 1'b0;
               end
            end
            APPLY: begin
               if (settle == SET_W'(SETTLE - 1)) begin
                  state  <= SAMPLE;
                  settle <= '0;
               end else begin
                  settle <= settle + SET_W'(1);
               end
            end
            SAMPLE: begin
               err_q <= err_nxt_c;
               if (mismatch_c) begin
                  mask_q[vec] <= 1'b1;
                  if (!fvalid_q) begin
                     first_q  <= vec;
                     fvalid_q <= 1'b1;
                  end
               end
               if (vec == LAST_VEC) begin
                  state  <= DONE;
                  abc    <= '0;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  pass_q <= (err_nxt_c == '0);
               end else begin
                  state  <= APPLY;
                  vec    <= vec + VEC_W'(1);
                  abc    <= vec + VEC_W'(1);
                  settle <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bif.A          = abc[A_BIT];
   assign bif.B          = abc[B_BIT];
   assign bif.C          = abc[C_BIT];
   assign bif.busy       = busy_q;
   assign bif.done       = done_q;
   assign bif.pass       = pass_q;
   assign bif.err_count  = err_q;
   assign bif.fail_mask  = mask_q;
   assign bif.first_fail = first_q;
   assign bif.fail_valid = fvalid_q;

endmodule
